// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and width limits for the bit-serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit combinational full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with registered sum, carry-out and signed overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end
  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, part_q, part_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             fa_s, fa_c, last;
  full_adder u_fa (.a(a_sr_q[0]), .b(b_sr_q[0]), .cin(c_q), .s(fa_s), .cout(fa_c));
  assign last = cnt_q == CW'(WIDTH - 1);
  // next-state: load on accept, one full-adder step per SHIFT edge, latch results on the MSB step
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    part_d  = part_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        a_sr_d  = a;
        b_sr_d  = b;
        c_d     = 1'b0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        part_d = {fa_s, part_q[WIDTH-1:1]};
        c_d    = fa_c;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          sum_d   = {fa_s, part_q[WIDTH-1:1]};
          cout_d  = fa_c;
          ovf_d   = c_q ^ fa_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously to abort any operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      part_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      part_q  <= part_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned/two's-complement adder: accepts two WIDTH-bit operands on a start pulse, adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop, and returns the registered sum, carry-out and signed overflow with a one-cycle done pulse. It is the additive counterpart to the team's combinational half subtractor. It serves as the area-minimal arithmetic unit in multi-cycle datapaths where a WIDTH-bit parallel adder is not justified.

## Interface
- WIDTH, default 8: operand/sum width in bits; legal range 2..32.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepting edge only.
- b  input  WIDTH  operand B, captured on the accepting edge only.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse, high while in DONE.
- sum  output  WIDTH  registered result (a+b) mod 2^WIDTH.
- cout  output  1  registered unsigned carry-out of bit WIDTH-1.
- ovf  output  1  registered signed overflow, carry-into-MSB XOR carry-out-of-MSB.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - With start=1 at an edge, load a and b into operand shift registers, clear the carry flop and clear the bit counter (width $clog2(WIDTH)), then go to SHIFT.
  - With start=0, stay in IDLE.
- SHIFT, per edge:
  - Compute full-adder bit s = a_sr[0]^b_sr[0]^c and carry c' = majority(a_sr[0], b_sr[0], c).
  - Shift a_sr and b_sr right by 1.
  - Shift s into the MSB of the partial-result register.
  - Set c <= c', then counter++.
- On the edge where counter == WIDTH-1, that edge's bit is the MSB:
  - sum <= {s, partial[WIDTH-1:1]}, cout <= c', ovf <= c ^ c'.
  - Go to DONE.
- DONE: go to IDLE unconditionally on the next edge.
- start is ignored in SHIFT and DONE. No queuing; a new operation needs start high in IDLE.
- Operand inputs a and b may change freely after the accepting edge.
- sum, cout and ovf change only on the SHIFT→DONE edge and hold until the next completion.
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, carry 0, counter 0, shift registers 0.
- Reset mid-operation aborts the operation; no done pulse is produced. On the first edge after reset deasserts, start is honoured.

## Timing
- Accept at edge k, then busy=1 from after edge k through edge k+WIDTH.
- done=1 and results valid for one cycle after edge k+WIDTH; busy=0 in that cycle.
- Fixed latency: WIDTH+1 edges from accept to return to IDLE.
- Earliest next accept is edge k+WIDTH+2, so throughput is one operation per WIDTH+2 cycles with start held high.
- Outputs are all registered or state-decoded; there is no combinational path from inputs to outputs.

## Structure
- Package serial_adder_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t.
  - Constants WIDTH_MIN=2 and WIDTH_MAX=32.
- Sub-module full_adder (a, b, cin → s, cout), purely combinational, instantiated once.
- Top: FSM, counter, two operand shift registers, partial-result register, output registers.
- Elaboration-time check: WIDTH within [WIDTH_MIN, WIDTH_MAX].

## Test plan
- WIDTH=8, a=100, b=55, start for one cycle → busy high 8 cycles, then done; sum=155, cout=0, ovf=1 (100+55 exceeds +127 signed).
- a=8'hFF, b=8'h01 → sum=8'h00, cout=1, ovf=0.
- a=8'h7F, b=8'h01 → sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 → sum=0, cout=1, ovf=1.
- start held high continuously with operand pairs (3,4) then (10,20) → done pulses exactly WIDTH+2 cycles apart; sums 7 and 30. Operand changes and start while busy have no effect.
- reset asserted asynchronously at bit 4 of an operation → all outputs 0 immediately, no done pulse. The next start with a=1, b=2 gives sum=3 after the normal latency.
- WIDTH=2 and WIDTH=32 exhaustive/random sweep against a+b reference → sum, cout and ovf match for all vectors; done is always exactly one cycle wide.
